// File: rtl/jt49_noise_seq_pkg.sv
// jt49_noise_seq_pkg: state encoding, table entry layout and duration decode for the noise sequencer
package jt49_noise_seq_pkg;
  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
  localparam int PER_LSB = 0;
  localparam int PER_W   = 5;
  localparam int DUR_LSB = 5;
  localparam int DUR_W   = 8;
  localparam int ENT_W   = DUR_LSB + DUR_W;
  function automatic logic [8:0] dur_cnt(input logic [DUR_W-1:0] d);
    return d == '0 ? 9'd256 : {1'b0, d};
  endfunction
endpackage

// File: rtl/jt49_noise_seq_tbl.sv
// jt49_noise_seq_tbl: step table, synchronous write port and asynchronous read port
// clk/rst_n: clock and async active-low reset (clears every entry)
// wr/waddr/wdata: write strobe, entry index, {dur, per}
// raddr/rdata: fetch index and entry read combinationally
module jt49_noise_seq_tbl
  import jt49_noise_seq_pkg::*;
#(
  parameter int STEPS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [AW-1:0]    waddr,
  input  logic [ENT_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [ENT_W-1:0] rdata
);
  logic [ENT_W-1:0] mem [STEPS];
  for (genvar i = 0; i < STEPS; i++) begin : g_ent
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mem[i] <= '0;
      else if (wr && waddr == AW'(i)) mem[i] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/jt49_noise_seq.sv
// jt49_noise_seq: table-driven noise period sequencer feeding jt49_noise
// clk/rst_n/cen: clock, async active-low reset, clock enable for sequencing
// wr/waddr/wdata: table write port, not gated by cen
// last/loop: final step index and wrap-around enable
// start/stop: one-clk pulses, held pending until the next cen cycle
// period/noise_en/busy/step: registered play outputs; done: one-clk completion pulse
module jt49_noise_seq
  import jt49_noise_seq_pkg::*;
#(
  parameter int STEPS = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          wr,
  input  logic [AW-1:0] waddr,
  input  logic [12:0]   wdata,
  input  logic [AW-1:0] last,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic [4:0]    period,
  output logic          noise_en,
  output logic          busy,
  output logic [AW-1:0] step,
  output logic          done
);
  state_t state, state_d;
  logic start_p, stop_p, st, sp, fetch, done_d;
  logic [8:0] cnt, cnt_d;
  logic [AW-1:0] faddr, step_d;
  logic [4:0] period_d;
  logic [ENT_W-1:0] rd;
  jt49_noise_seq_tbl #(.STEPS(STEPS), .AW(AW)) u_tbl (
    .clk(clk), .rst_n(rst_n), .wr(wr), .waddr(waddr), .wdata(wdata),
    .raddr(faddr), .rdata(rd)
  );
  // a pulse arriving on a cen cycle is acted on in that same cycle
  assign st = start_p | start;
  assign sp = stop_p | stop;
  assign busy = state == PLAY;
  assign noise_en = busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      step    <= '0;
      period  <= '0;
      done    <= 1'b0;
      start_p <= 1'b0;
      stop_p  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      step    <= step_d;
      period  <= period_d;
      done    <= done_d;
      start_p <= cen ? 1'b0 : st;
      stop_p  <= cen ? 1'b0 : sp;
    end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    step_d  = step;
    done_d  = 1'b0;
    fetch   = 1'b0;
    faddr   = '0;
    if (cen) begin
      if (state == IDLE) fetch = st && !sp;
      else if (sp) state_d = IDLE;
      else if (st) fetch = 1'b1;
      else if (cnt > 9'd1) cnt_d = cnt - 1'b1;
      else if (step != last) begin
        fetch = 1'b1;
        faddr = step + 1'b1;
      end else if (loop) fetch = 1'b1;
      else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    period_d = fetch ? rd[PER_LSB +: PER_W] : period;
    if (fetch) begin
      state_d = PLAY;
      step_d  = faddr;
      cnt_d   = dur_cnt(rd[DUR_LSB +: DUR_W]);
    end
  end
endmodule

// File: tb/tb_jt49_noise_seq.sv
// tb_jt49_noise_seq: directed and randomized checks of the noise sequencer against a tick-expansion model
module tb_jt49_noise_seq;
  logic clk, rst_n, cen, wr, loop, start, stop;
  logic [2:0] waddr, last, step;
  logic [12:0] wdata;
  logic [4:0] period;
  logic noise_en, busy, done;
  logic [12:0] tbl_m [8];
  int q[$], sq[$];
  int exp_per, exp_step, vec, mis;
  bit exp_busy;
  jt49_noise_seq dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .waddr(waddr), .wdata(wdata),
    .last(last), .loop(loop), .start(start), .stop(stop), .period(period),
    .noise_en(noise_en), .busy(busy), .step(step), .done(done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $fatal(1, "FAIL timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input bit dn);
    chk("period", 32'(period), exp_per);
    chk("step", 32'(step), exp_step);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("noise_en", 32'(noise_en), 32'(exp_busy));
    chk("done", 32'(done), 32'(dn));
  endtask
  task automatic cyc(input bit c);
    cen = c;
    @(posedge clk);
    #1;
    start = 0;
    stop = 0;
    wr = 0;
  endtask
  task automatic wr_tbl(input int a, input int d, input int p);
    wr = 1;
    waddr = 3'(a);
    wdata = {8'(d), 5'(p)};
    tbl_m[a] = wdata;
    cyc(0);
  endtask
  // expected per-tick period and step index, from step durations in play order
  task automatic build(input int n0);
    int i, c;
    q.delete();
    sq.delete();
    i = 0;
    while (1) begin
      c = tbl_m[i][12:5] == 0 ? 256 : int'(tbl_m[i][12:5]);
      repeat (c) begin
        q.push_back(int'(tbl_m[i][4:0]));
        sq.push_back(i);
      end
      if (i == int'(last)) begin
        if (!loop) break;
        i = 0;
      end else i = (i + 1) % 8;
      if (loop && q.size() >= n0) break;
    end
  endtask
  task automatic play(input int n0, input int cper, input int wcyc, input int wad, input logic [12:0] wv);
    int n;
    bit c, dn;
    if (wcyc >= 0) tbl_m[wad] = wv;
    build(n0);
    n = n0 == 0 ? q.size() + 2 : n0;
    start = 1;
    for (int t = 0; t < n; t++)
      for (int p = 0; p < cper; p++) begin
        c = p == cper - 1;
        dn = 0;
        if (c) begin
          if (t < q.size()) begin
            exp_per = q[t];
            exp_step = sq[t];
            exp_busy = 1;
          end else begin
            dn = exp_busy;
            exp_busy = 0;
          end
        end
        if (t * cper + p == wcyc) begin
          wr = 1;
          waddr = 3'(wad);
          wdata = wv;
        end
        cyc(c);
        chk_out(dn);
      end
  endtask
  initial begin
    vec = 0;
    mis = 0;
    rst_n = 1;
    {cen, wr, waddr, wdata, last, loop, start, stop} = '0;
    for (int i = 0; i < 8; i++) tbl_m[i] = '0;
    exp_per = 0;
    exp_step = 0;
    exp_busy = 0;
    #3 rst_n = 0;
    #10 chk_out(0);
    @(negedge clk) rst_n = 1;
    cyc(0);
    chk_out(0);
    wr_tbl(0, 3, 5);
    last = 0;
    loop = 0;
    play(0, 1, -1, 0, '0);
    wr_tbl(0, 2, 1);
    wr_tbl(1, 1, 7);
    wr_tbl(2, 4, 31);
    last = 2;
    loop = 1;
    play(12, 4, -1, 0, '0);
    wr_tbl(0, 0, 9);
    last = 0;
    loop = 0;
    play(0, 1, -1, 0, '0);
    wr_tbl(0, 3, 4);
    wr_tbl(1, 5, 6);
    wr_tbl(2, 4, 8);
    last = 2;
    play(10, 1, -1, 0, '0);
    play(0, 1, -1, 0, '0);
    play(5, 2, -1, 0, '0);
    stop = 1;
    cyc(0);
    chk_out(0);
    cyc(1);
    exp_busy = 0;
    chk_out(0);
    cyc(1);
    chk_out(0);
    start = 1;
    cyc(1);
    exp_per = 4;
    exp_step = 0;
    exp_busy = 1;
    chk_out(0);
    start = 1;
    stop = 1;
    cyc(1);
    exp_busy = 0;
    chk_out(0);
    cyc(1);
    chk_out(0);
    wr_tbl(0, 3, 11);
    wr_tbl(1, 2, 12);
    last = 1;
    play(0, 1, 1, 1, {8'd4, 5'd20});
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) wr_tbl(i, $urandom_range(1, 5), $urandom_range(0, 31));
      last = 3'($urandom_range(0, 7));
      loop = 1'($urandom_range(0, 1));
      play(loop ? 40 : 0, $urandom_range(1, 3), -1, 0, '0);
    end
    loop = 0;
    play(5, 1, -1, 0, '0);
    #2 rst_n = 0;
    #1;
    exp_per = 0;
    exp_step = 0;
    exp_busy = 0;
    chk_out(0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 8; i++) tbl_m[i] = '0;
    last = 0;
    play(0, 1, -1, 0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
